gray_counter_n: RTL and testbench

Parametrised Gray-code counter, successor to the fixed 4-bit Gray counter in the EXPT series. Generalises width and adds count enable, up/down direction, synchronous parallel load, binary readback and wrap/terminal-count flags. Used wherever a single-bit-change count is needed, e.g. FIFO pointers crossing clock domains and position encoders. The Gray output is a registered, glitch-free source.

---
 rtl/gray_counter_n_if.sv | 24 ++
 rtl/gray_counter_n.sv | 58 +++++
 tb/tb_gray_counter_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_n_if.sv
// Handshake/data bundle for gray_counter_n: control inputs from the master,
// Gray/binary count and flags back from the counter.
interface gray_counter_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] bin;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  out, bin, tc, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output out, bin, tc, wrap
  );
endinterface

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray counter with load, binary readback and wrap/tc flags.
// Define GRAY_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  gray_counter_n_if.slave  bus
);

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_bound;

  // Boundary in the currently selected direction; doubles as tc.
  assign at_bound = bus.up ? (bin_q == AllOnes) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      bin_d = bus.load_val;
    end else if (bus.en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (!at_bound) begin
        bin_d = bus.up ? (bin_q + One) : (bin_q - One);
      end
`else
      bin_d  = bus.up ? (bin_q + One) : (bin_q - One);
      wrap_d = at_bound;
`endif
    end
    // Gray value is computed ahead and registered so out is a clean flop output.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = gray_q;
  assign bus.bin  = bin_q;
  assign bus.tc   = at_bound;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Self-checking bench for gray_counter_n: directed literal checks plus random
// stimulus compared every cycle against an arithmetic model of the count.
module tb_gray_counter_n;
  localparam int unsigned W   = 4;
  localparam int unsigned MAX = (1 << W) - 1;

  logic clk;
  logic rstn;

  gray_counter_n_if #(.WIDTH(W)) ifc ();

  gray_counter_n #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  int n_vec;
  int n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer count modulo 2^W.
  int unsigned m_b;
  bit          m_wrap;
  bit          m_step;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_b    <= 0;
      m_wrap <= 1'b0;
      m_step <= 1'b0;
    end else if (ifc.load) begin
      m_b    <= int'(ifc.load_val);
      m_wrap <= 1'b0;
      m_step <= 1'b0;
    end else if (ifc.en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (ifc.up) m_b <= (m_b == MAX) ? m_b : m_b + 1;
      else        m_b <= (m_b == 0)   ? m_b : m_b - 1;
      m_wrap <= 1'b0;
      m_step <= ifc.up ? (m_b != MAX) : (m_b != 0);
`else
      if (ifc.up) m_b <= (m_b + 1) % (MAX + 1);
      else        m_b <= (m_b + MAX) % (MAX + 1);
      m_wrap <= ifc.up ? (m_b == MAX) : (m_b == 0);
      m_step <= 1'b1;
`endif
    end else begin
      m_wrap <= 1'b0;
      m_step <= 1'b0;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  logic [W-1:0] prev_out;
  initial prev_out = '0;
  always @(negedge clk) begin
    chk("bin",  32'(ifc.bin),  m_b);
    chk("out",  32'(ifc.out),  m_b ^ (m_b >> 1));
    chk("wrap", 32'(ifc.wrap), 32'(m_wrap));
    chk("tc",   32'(ifc.tc),   32'(ifc.up ? (m_b == MAX) : (m_b == 0)));
    if (m_step && rstn) chk("one_bit_step", $countones(ifc.out ^ prev_out), 1);
    prev_out = ifc.out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.en   = 1'b0;
    ifc.load = 1'b0;
    rstn     = 1'b0;
    #1;
    chk("rst_out", 32'(ifc.out), 0);
    tick();
    rstn = 1'b1;
  endtask

  logic [3:0] gray_tbl [16];

  initial begin
    gray_tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    n_vec        = 0;
    n_err        = 0;
    rstn         = 1'b0;
    ifc.en       = 1'b0;
    ifc.up       = 1'b1;
    ifc.load     = 1'b0;
    ifc.load_val = '0;
    #2;
    chk("rst_async_out",  32'(ifc.out),  0);
    chk("rst_async_bin",  32'(ifc.bin),  0);
    chk("rst_async_wrap", 32'(ifc.wrap), 0);
    tick();
    rstn = 1'b1;

`ifndef GRAY_COUNTER_SAT_EN
    // Full up-count through one wrap.
    ifc.en = 1'b1;
    ifc.up = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("seq_out",  32'(ifc.out),  32'(gray_tbl[(i + 1) % 16]));
      chk("seq_wrap", 32'(ifc.wrap), (i == 15) ? 1 : 0);
    end

    // Single down step from reset wraps to all-ones.
    do_reset();
    ifc.up = 1'b0;
    ifc.en = 1'b1;
    #1;
    chk("down_tc_pre", 32'(ifc.tc), 1);
    tick();
    chk("down_out",  32'(ifc.out),  32'h8);
    chk("down_bin",  32'(ifc.bin),  32'hF);
    chk("down_wrap", 32'(ifc.wrap), 1);

    // Load beats enable, then hold.
    ifc.up       = 1'b1;
    ifc.load     = 1'b1;
    ifc.load_val = 4'hA;
    tick();
    chk("load_out",  32'(ifc.out),  32'hF);
    chk("load_bin",  32'(ifc.bin),  32'hA);
    chk("load_wrap", 32'(ifc.wrap), 0);
    ifc.load = 1'b0;
    ifc.en   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out", 32'(ifc.out), 32'hF);
    end

    // Async reset mid-cycle from bin=0101.
    do_reset();
    ifc.en = 1'b1;
    ifc.up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_abort_bin", 32'(ifc.bin), 32'h5);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_out", 32'(ifc.out), 0);
    chk("abort_bin", 32'(ifc.bin), 0);
    #1;
    rstn = 1'b1;
    tick();
    chk("resume_out", 32'(ifc.out), 32'h1);

    // Direction toggling at the bottom and top boundaries.
    do_reset();
    ifc.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifc.up = (i % 2 == 0);
      tick();
      chk("alt_out",  32'(ifc.out),  (i % 2 == 0) ? 1 : 0);
      chk("alt_wrap", 32'(ifc.wrap), 0);
    end
    ifc.en       = 1'b0;
    ifc.load     = 1'b1;
    ifc.load_val = 4'hF;
    tick();
    ifc.load = 1'b0;
    ifc.en   = 1'b1;
    ifc.up   = 1'b1;
    tick();
    chk("top_up_bin",  32'(ifc.bin),  0);
    chk("top_up_wrap", 32'(ifc.wrap), 1);
    ifc.up = 1'b0;
    tick();
    chk("top_dn_bin",  32'(ifc.bin),  32'hF);
    chk("top_dn_wrap", 32'(ifc.wrap), 1);
`else
    ifc.en = 1'b1;
    ifc.up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_wrap", 32'(ifc.wrap), 0);
    end
    chk("sat_up_out", 32'(ifc.out), 32'h8);
    chk("sat_up_bin", 32'(ifc.bin), 32'hF);
    do_reset();
    ifc.en = 1'b1;
    ifc.up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_dn_out", 32'(ifc.out), 0);
    end
`endif

    // Random traffic with occasional mid-cycle async reset.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r            = $urandom_range(0, 99);
      ifc.load     = (r < 8);
      ifc.en       = ($urandom_range(0, 3) != 0);
      ifc.up       = $urandom_range(0, 1) == 1;
      ifc.load_val = W'($urandom);
      tick();
      if (r >= 97) begin
        #2;
        rstn = 1'b0;
        #1;
        chk("rnd_abort_bin", 32'(ifc.bin), 0);
        chk("rnd_abort_wrap", 32'(ifc.wrap), 0);
        rstn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
